// File: rtl/mem_stage.sv
// mem_stage: memory-access / write-back stage. Runs the load/store bus handshake
// for one ALU result bundle, then commits rD and PC with one-cycle strobes.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        memory_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              write_rD,
  input  logic              write_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rD_we,
  output logic [DATA_W-1:0] rD_data,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    COMMIT = 2'b10
  } state_t;

  localparam logic [1:0]  MEM_READ   = 2'b01;
  localparam logic [1:0]  MEM_WRITE  = 2'b10;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t              state_r;
  logic [1:0]          mode_r;
  logic [DATA_W-1:0]   alu_r;
  logic                write_rd_r;
  logic                write_pc_r;
  logic [15:0]         timer_r;

  // Stage FSM: bundle latch, bus handshake with timeout, and commit strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mode_r     <= 2'b00;
      alu_r      <= '0;
      write_rd_r <= 1'b0;
      write_pc_r <= 1'b0;
      timer_r    <= 16'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rD_we      <= 1'b0;
      rD_data    <= '0;
      pc_we      <= 1'b0;
      pc_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            mode_r     <= memory_mode;
            alu_r      <= alu_out;
            write_rd_r <= write_rD;
            write_pc_r <= write_pc;
            timer_r    <= 16'd0;
            busy       <= 1'b1;
            if (memory_mode == MEM_READ || memory_mode == MEM_WRITE) begin
              state_r   <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= (memory_mode == MEM_WRITE);
              mem_addr  <= alu_out;
              mem_wdata <= store_data;
            end else begin
              // NOP and the reserved encoding skip the bus entirely.
              state_r <= COMMIT;
              done    <= 1'b1;
              pc_we   <= write_pc;
              pc_data <= alu_out;
              rD_we   <= write_rD;
              rD_data <= alu_out;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Ack takes priority over a timeout expiring on the same edge.
            state_r <= COMMIT;
            mem_req <= 1'b0;
            timer_r <= 16'd0;
            done    <= 1'b1;
            pc_we   <= write_pc_r;
            pc_data <= alu_r;
            rD_we   <= write_rd_r && (mode_r != MEM_WRITE);
            rD_data <= (mode_r == MEM_READ) ? mem_rdata : alu_r;
          end else if (timer_r == TIMER_LAST) begin
            state_r <= IDLE;
            mem_req <= 1'b0;
            timer_r <= 16'd0;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        COMMIT: begin
          state_r <= IDLE;
          done    <= 1'b0;
          pc_we   <= 1'b0;
          rD_we   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
          done    <= 1'b0;
          pc_we   <= 1'b0;
          rD_we   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset/enable corner sequence,
// and randomized back-to-back bundles checked against a transaction-level model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  memory_mode;
  logic [15:0] alu_out;
  logic [15:0] store_data;
  logic        write_rD;
  logic        write_pc;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        rD_we;
  logic [15:0] rD_data;
  logic        pc_we;
  logic [15:0] pc_data;
  logic        busy;
  logic        done;
  logic        error;

  mem_stage #(.DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .memory_mode(memory_mode),
    .alu_out(alu_out), .store_data(store_data), .write_rD(write_rD), .write_pc(write_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rD_we(rD_we), .rD_data(rD_data),
    .pc_we(pc_we), .pc_data(pc_data), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bundle: inputs, bus behaviour (ack delay in REQ cycles) and expected outcome.
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [15:0] rdata;
    logic        wrd;
    logic        wpc;
    int          delay;
    int          exp_req;
    logic        exp_done;
    logic        exp_error;
    logic        exp_rd_we;
    logic [15:0] exp_rd_data;
    logic        exp_pc_we;
    logic [15:0] exp_pc_data;
    logic        exp_mem_we;
  } vec_t;

  typedef struct {
    int          req_cnt;
    int          done_cnt;
    int          err_cnt;
    int          rd_we_cnt;
    int          pc_we_cnt;
    int          idle_at;
    logic        stable;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd_data;
    logic [15:0] pc_data;
  } obs_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic [15:0] alu, input logic [15:0] sd,
                              input logic [15:0] rdata, input logic wrd, input logic wpc, input int delay,
                              input int ereq, input logic edone, input logic eerr, input logic erdwe,
                              input logic [15:0] erdd, input logic epcwe, input logic [15:0] epcd,
                              input logic ememwe);
    vec_t v;
    v.mode = mode; v.alu = alu; v.sd = sd; v.rdata = rdata; v.wrd = wrd; v.wpc = wpc;
    v.delay = delay; v.exp_req = ereq; v.exp_done = edone; v.exp_error = eerr;
    v.exp_rd_we = erdwe; v.exp_rd_data = erdd; v.exp_pc_we = epcwe; v.exp_pc_data = epcd;
    v.exp_mem_we = ememwe;
    return v;
  endfunction

  // Reference model: outcome of one bundle from the stage's rules, no cycle-level state.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic is_mem;
    logic timed;
    r = v;
    is_mem        = (v.mode == 2'd1) || (v.mode == 2'd2);
    timed         = is_mem && (v.delay >= TO);
    r.exp_req     = !is_mem ? 0 : (timed ? TO : v.delay + 1);
    r.exp_done    = !timed;
    r.exp_error   = timed;
    r.exp_rd_we   = !timed && v.wrd && (v.mode != 2'd2);
    r.exp_rd_data = (v.mode == 2'd1) ? v.rdata : v.alu;
    r.exp_pc_we   = !timed && v.wpc;
    r.exp_pc_data = v.alu;
    r.exp_mem_we  = (v.mode == 2'd2);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the first negedge it is idle again.
  task automatic run_txn(input vec_t v, output obs_t o);
    o = '{default: 0};
    o.stable = 1'b1;
    enable = 1'b1; memory_mode = v.mode; alu_out = v.alu; store_data = v.sd;
    write_rD = v.wrd; write_pc = v.wpc; mem_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_req) begin
        o.req_cnt++;
        if (o.req_cnt == 1) begin
          o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
      end
      if (done) begin
        o.done_cnt++; o.rd_data = rD_data; o.pc_data = pc_data;
      end
      if (error) o.err_cnt++;
      if (rD_we) o.rd_we_cnt++;
      if (pc_we) o.pc_we_cnt++;
      if (!busy) begin
        o.idle_at = k;
        break;
      end
      // Junk on ack/enable outside their windows must be ignored by the stage.
      mem_ack   = mem_req ? (o.req_cnt == v.delay + 1) : 1'($urandom_range(0, 1));
      mem_rdata = (mem_req && mem_ack) ? v.rdata : 16'($urandom);
      enable      = 1'($urandom_range(0, 1));
      memory_mode = 2'($urandom);
      alu_out     = 16'($urandom);
      store_data  = 16'($urandom);
      write_rD    = 1'($urandom);
      write_pc    = 1'($urandom);
    end
    enable  = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input obs_t o);
    check({tag, "_req_cycles"}, o.req_cnt, v.exp_req);
    check({tag, "_done"}, o.done_cnt, {31'd0, v.exp_done});
    check({tag, "_error"}, o.err_cnt, {31'd0, v.exp_error});
    check({tag, "_rd_we"}, o.rd_we_cnt, {31'd0, v.exp_rd_we});
    check({tag, "_pc_we"}, o.pc_we_cnt, {31'd0, v.exp_pc_we});
    check({tag, "_idle_at"}, o.idle_at, v.exp_req + (v.exp_done ? 2 : 1));
    if (v.exp_done) begin
      check({tag, "_rd_data"}, o.rd_data, v.exp_rd_data);
      check({tag, "_pc_data"}, o.pc_data, v.exp_pc_data);
    end
    if (v.exp_req > 0) begin
      check({tag, "_mem_we"}, o.we, v.exp_mem_we);
      check({tag, "_mem_addr"}, o.addr, v.alu);
      check({tag, "_mem_wdata"}, o.wdata, v.sd);
      check({tag, "_bus_stable"}, o.stable, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    obs_t o;

    tbl[0] = mk(2'b00, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0);
    tbl[1] = mk(2'b01, 16'h0040, 16'h1111, 16'hBEEF, 1'b1, 1'b0, 2,  3, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0040, 1'b0);
    tbl[2] = mk(2'b10, 16'h0080, 16'h5A5A, 16'h0000, 1'b1, 1'b0, 0,  1, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0, 16'h0080, 1'b1);
    tbl[3] = mk(2'b00, 16'h00FE, 16'h0000, 16'h0000, 1'b0, 1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 16'h00FE, 1'b1, 16'h00FE, 1'b0);
    tbl[4] = mk(2'b01, 16'h0100, 16'h2222, 16'hDEAD, 1'b1, 1'b1, 99, 4, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[5] = mk(2'b11, 16'h7777, 16'h3333, 16'h0000, 1'b1, 1'b1, 0,  0, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b1, 16'h7777, 1'b0);
    tbl[6] = mk(2'b10, 16'h0200, 16'hA5A5, 16'h0000, 1'b1, 1'b1, 3,  4, 1'b1, 1'b0, 1'b0, 16'h0200, 1'b1, 16'h0200, 1'b1);
    tbl[7] = mk(2'b01, 16'h0300, 16'h4444, 16'hC0DE, 1'b1, 1'b0, 3,  4, 1'b1, 1'b0, 1'b1, 16'hC0DE, 1'b0, 16'h0300, 1'b0);

    reset = 1'b1; enable = 1'b0; memory_mode = 2'b00; alu_out = 16'h0000; store_data = 16'h0000;
    write_rD = 1'b0; write_pc = 1'b0; mem_rdata = 16'h0000; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_rd_we", rD_we, 1'b0);
    check("rst_rd_data", rD_data, 16'h0000);
    check("rst_pc_we", pc_we, 1'b0);
    check("rst_pc_data", pc_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], o);
      check_txn($sformatf("tbl%0d", i), tbl[i], o);
    end

    // Enable while busy is ignored; reset in REQ drops everything with no commit or error.
    enable = 1'b1; memory_mode = 2'b01; alu_out = 16'h0123; store_data = 16'h0456;
    @(negedge clk);
    check("midreq_req_up", mem_req, 1'b1);
    enable = 1'b1; memory_mode = 2'b00; alu_out = 16'h0999;
    @(negedge clk);
    check("busy_enable_req", mem_req, 1'b1);
    check("busy_enable_addr", mem_addr, 16'h0123);
    check("busy_enable_done", done, 1'b0);
    enable = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midreq_rst_req", mem_req, 1'b0);
    check("midreq_rst_busy", busy, 1'b0);
    check("midreq_rst_done", done, 1'b0);
    check("midreq_rst_error", error, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_error", error, 1'b0);
    check("post_rst_done", done, 1'b0);

    for (int i = 0; i < 200; i++) begin
      v.mode  = 2'($urandom_range(0, 3));
      v.alu   = 16'($urandom);
      v.sd    = 16'($urandom);
      v.rdata = 16'($urandom);
      v.wrd   = 1'($urandom);
      v.wpc   = 1'($urandom);
      v.delay = int'($urandom_range(0, 5));
      v = model(v);
      run_txn(v, o);
      check_txn($sformatf("rnd%0d", i), v, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
